// File: rtl/alu_pkg.sv
// ==== alu_pkg - opcodes, FSM state type and default width for the shared ALU (rev 1.0) ====
`default_nettype none

package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ==== alu_core - combinational ALU datapath: add/sub/and/or/xor/not (rev 1.0) ====
`default_nettype none

module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // The extra top bit of the widened subtract is the unsigned borrow.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         default: result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ==== alu_arbiter - two-requester round-robin arbiter and sequencer for the shared ALU (rev 1.0) ====
`default_nettype none

module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_0,
   input  logic             req_valid_1,
   output logic             req_ready_0,
   output logic             req_ready_1,
   input  logic [2:0]       req_op_0,
   input  logic [2:0]       req_op_1,
   input  logic [WIDTH-1:0] req_a_0,
   input  logic [WIDTH-1:0] req_a_1,
   input  logic [WIDTH-1:0] req_b_0,
   input  logic [WIDTH-1:0] req_b_1,
   output logic             rsp_valid_0,
   output logic             rsp_valid_1,
   input  logic             rsp_ready_0,
   input  logic             rsp_ready_1,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             busy,
   output logic             grant_id
);

   state_t           state;
   logic             ptr;
   logic [2:0]       op_lat;
   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;
   logic             any_valid;
   logic             win;
   logic             owner_ready;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   // A lone requester wins outright; the pointer only breaks ties.
   assign any_valid   = req_valid_0 | req_valid_1;
   assign win         = (req_valid_0 & req_valid_1) ? ptr : req_valid_1;
   assign req_ready_0 = (state == IDLE) & any_valid & ~win;
   assign req_ready_1 = (state == IDLE) & any_valid & win;
   assign owner_ready = grant_id ? rsp_ready_1 : rsp_ready_0;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .op     (op_lat),
      .a      (a_lat),
      .b      (b_lat),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 1'b0;
         op_lat      <= '0;
         a_lat       <= '0;
         b_lat       <= '0;
         grant_id    <= 1'b0;
         busy        <= 1'b0;
         rsp_valid_0 <= 1'b0;
         rsp_valid_1 <= 1'b0;
         rsp_result  <= '0;
         rsp_carry   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id <= win;
                  op_lat   <= win ? req_op_1 : req_op_0;
                  a_lat    <= win ? req_a_1  : req_a_0;
                  b_lat    <= win ? req_b_1  : req_b_0;
                  busy     <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               rsp_result  <= alu_result;
               rsp_carry   <= alu_carry;
               rsp_valid_0 <= ~grant_id;
               rsp_valid_1 <= grant_id;
               state       <= RESP;
            end
            RESP: begin
               if (owner_ready) begin
                  ptr         <= ~grant_id;
                  rsp_valid_0 <= 1'b0;
                  rsp_valid_1 <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ==== tb_alu_arbiter - randomized scoreboard bench for the round-robin ALU arbiter (rev 1.0) ====
`default_nettype none

module tb_alu_arbiter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vld [2];
   logic [2:0]   op  [2];
   logic [W-1:0] a   [2];
   logic [W-1:0] b   [2];
   logic         rr  [2];
   logic         rdy0, rdy1, rv0, rv1;
   logic [W-1:0] res;
   logic         carry, busy, gid;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   int grant_log [$];
   int acc_cyc   [$];
   bit rr_rand = 1'b0;

   int m_phase = 0;
   int m_ptr   = 0;
   int m_id    = 0;
   bit chk_rst = 1'b0;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_0 (vld[0]),
      .req_valid_1 (vld[1]),
      .req_ready_0 (rdy0),
      .req_ready_1 (rdy1),
      .req_op_0    (op[0]),
      .req_op_1    (op[1]),
      .req_a_0     (a[0]),
      .req_a_1     (a[1]),
      .req_b_0     (b[0]),
      .req_b_1     (b[1]),
      .rsp_valid_0 (rv0),
      .rsp_valid_1 (rv1),
      .rsp_ready_0 (rr[0]),
      .rsp_ready_1 (rr[1]),
      .rsp_result  (res),
      .rsp_carry   (carry),
      .busy        (busy),
      .grant_id    (gid)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // Reference ALU from the opcode table, using plain integer arithmetic.
   function automatic logic [8:0] ref_alu(logic [2:0] o, int x, int y);
      int r;
      int c;
      r = 0;
      c = 0;
      case (o)
         3'd0: begin r = x + y; c = (r > 255) ? 1 : 0; r = r % 256; end
         3'd1: begin c = (x < y) ? 1 : 0; r = (x - y + 256) % 256; end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = 255 - x;
         default: r = 0;
      endcase
      return {c[0], r[7:0]};
   endfunction

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: tracks the transaction phase from the handshake rules and scores outputs.
   initial forever begin
      int w;
      logic [8:0] exp_rsp;
      @(negedge clk);
      if (chk_rst) begin
         check("reset_result", res, 0);
         check("reset_carry", carry, 0);
         check("reset_grant_id", gid, 0);
         chk_rst = 1'b0;
      end
      case (m_phase)
         0: begin
            check("idle_busy", busy, 0);
            check("idle_rsp_valid", {rv1, rv0}, 0);
            if (vld[0] || vld[1]) begin
               w = (vld[0] && vld[1]) ? m_ptr : (vld[1] ? 1 : 0);
               check("ready_grant", {rdy1, rdy0}, (w == 1) ? 2 : 1);
               if (!rst) begin
                  m_phase = 1;
                  m_id    = w;
                  grant_log.push_back(w);
                  acc_cyc.push_back(cyc);
               end
            end else begin
               check("ready_none", {rdy1, rdy0}, 0);
            end
         end
         1: begin
            check("exec_busy", busy, 1);
            check("exec_grant_id", gid, m_id);
            check("exec_ready", {rdy1, rdy0}, 0);
            check("exec_rsp_valid", {rv1, rv0}, 0);
            m_phase = 2;
         end
         default: begin
            check("resp_busy", busy, 1);
            check("resp_grant_id", gid, m_id);
            check("resp_ready", {rdy1, rdy0}, 0);
            check("resp_valid", {rv1, rv0}, (m_id == 1) ? 2 : 1);
            if ((m_id == 1 ? q1.size() : q0.size()) == 0) begin
               check("scoreboard_empty", 0, 1);
            end else begin
               exp_rsp = (m_id == 1) ? q1[0] : q0[0];
               check("resp_carry_result", {carry, res}, exp_rsp);
               if (rr[m_id]) begin
                  if (m_id == 1) void'(q1.pop_front());
                  else           void'(q0.pop_front());
                  m_ptr   = 1 - m_id;
                  m_phase = 0;
               end
            end
         end
      endcase
      if (rst) begin
         m_phase = 0;
         m_ptr   = 0;
         q0.delete();
         q1.delete();
         chk_rst = 1'b1;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rr_rand) begin
         rr[0] = 1'($urandom_range(1));
         rr[1] = 1'($urandom_range(1));
      end
   end

   task automatic issue(int id, logic [2:0] o, logic [7:0] x, logic [7:0] y);
      bit done;
      done    = 1'b0;
      vld[id] = 1'b1;
      op[id]  = o;
      a[id]   = x;
      b[id]   = y;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if ((id == 0 ? rdy0 : rdy1) && !rst) begin
            if (id == 0) q0.push_back(ref_alu(o, x, y));
            else         q1.push_back(ref_alu(o, x, y));
            done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      vld[id] = 1'b0;
      op[id]  = 3'($urandom);
      a[id]   = 8'($urandom);
      b[id]   = 8'($urandom);
      if (!done) check("issue_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_phase != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (m_phase != 0) check("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic rand_driver(int id, int count);
      for (int k = 0; k < count; k++) begin
         repeat ($urandom_range(3)) @(posedge clk);
         #0;
         issue(id, 3'($urandom), 8'($urandom), 8'($urandom));
      end
   endtask

   initial begin
      int base;
      for (int i = 0; i < 2; i++) begin
         vld[i] = 1'b0; op[i] = '0; a[i] = '0; b[i] = '0; rr[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Single ADD on requester 0
      rr[0] = 1'b1;
      issue(0, 3'b000, 8'd5, 8'd3);
      wait_idle();

      // Opcode sweep on requester 1, then carry/borrow corners
      rr[1] = 1'b1;
      for (int o = 1; o <= 6; o++) issue(1, 3'(o), 8'd5, 8'd3);
      issue(1, 3'b111, 8'd5, 8'd3);
      issue(1, 3'b000, 8'd200, 8'd100);
      issue(1, 3'b001, 8'd3, 8'd5);
      wait_idle();

      // Contention from a fresh reset: grants must alternate starting at 0
      pulse_reset();
      base = grant_log.size();
      fork
         for (int k = 0; k < 4; k++) issue(0, 3'($urandom), 8'($urandom), 8'($urandom));
         for (int k = 0; k < 4; k++) issue(1, 3'($urandom), 8'($urandom), 8'($urandom));
      join
      wait_idle();
      for (int k = 0; k < 8; k++) check("contention_order", grant_log[base + k], k % 2);

      // Backpressure on requester 0 while requester 1 waits
      rr[0] = 1'b0;
      base  = grant_log.size();
      fork
         issue(0, 3'b000, 8'd250, 8'd9);
         issue(1, 3'b100, 8'hA5, 8'h0F);
         begin
            for (int n = 0; n < 50 && m_phase != 2; n++) @(negedge clk);
            repeat (5) @(posedge clk);
            #1;
            rr[0] = 1'b1;
         end
      join
      wait_idle();
      check("backpressure_first", grant_log[base], 0);
      check("backpressure_second", grant_log[base + 1], 1);

      // Reset during EXEC, after a completion has moved the pointer to 1
      issue(0, 3'b011, 8'd1, 8'd2);
      wait_idle();
      rr[1] = 1'b0;
      issue(1, 3'b001, 8'd9, 8'd4);
      pulse_reset();
      rr[1] = 1'b1;
      base  = grant_log.size();
      fork
         issue(0, 3'b010, 8'hF0, 8'h3C);
         issue(1, 3'b101, 8'h0F, 8'h00);
      join
      wait_idle();
      check("post_reset_ptr_first", grant_log[base], 0);
      check("post_reset_ptr_second", grant_log[base + 1], 1);

      // Reset during RESP
      rr[0] = 1'b0;
      issue(0, 3'b000, 8'd77, 8'd88);
      @(posedge clk);
      #1;
      pulse_reset();
      rr[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Lone requester 1, back to back: one accept every 3 cycles
      base = acc_cyc.size();
      for (int k = 0; k < 4; k++) issue(1, 3'($urandom), 8'($urandom), 8'($urandom));
      wait_idle();
      for (int k = 1; k < 4; k++) begin
         check("lone_interval", acc_cyc[base + k] - acc_cyc[base + k - 1], 3);
         check("lone_grant", grant_log[base + k], 1);
      end

      // Randomized traffic with random response backpressure
      rr_rand = 1'b1;
      fork
         rand_driver(0, 20);
         rand_driver(1, 20);
      join
      rr_rand = 1'b0;
      @(posedge clk);
      #2;
      rr[0] = 1'b1;
      rr[1] = 1'b1;
      wait_idle();

      repeat (5) @(posedge clk);
      #1;
      check("final_idle", m_phase, 0);
      check("queues_empty", q0.size() + q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
